// File: rtl/dff_write_arbiter.sv
// dff_write_arbiter: grants one of NREQ requesters write access to a shared
// enabled D flip-flop and drives its en/d from the current owner. Each
// owner's tenure is capped at MAX_BURST cycles. When a tenure expires, the
// expired owner is skipped for the arbitration that happens at that edge.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin selection.
// Without it, the lowest eligible index wins.
//
// state | meaning
// IDLE  | no owner; gnt/en/d held at 0, arbitrate every edge
// GRANT | one-hot gnt owns the flip-flop; burst_cnt counts tenure cycles
module dff_write_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_d,
  input  logic            q,
  output logic [NREQ-1:0] gnt,
  output logic            en,
  output logic            d,
  output logic            busy,
  output logic            q_out
);

  localparam int         PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic            en_nxt, d_nxt;
  logic [3:0]      burst_cnt, cnt_nxt;
  logic [PW-1:0]   own_idx;
  logic [PW-1:0]   win_idx;
  logic            win_vld;
  logic            expired;
  logic [NREQ-1:0] elig;

`ifdef ARB_ROUND_ROBIN_EN
  logic [PW-1:0] ptr, ptr_nxt;

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction
`endif

  assign busy  = (state == GRANT);
  assign q_out = q;

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      en        <= 1'b0;
      d         <= 1'b0;
      burst_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr       <= '0;
`endif
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      en        <= en_nxt;
      d         <= d_nxt;
      burst_cnt <= cnt_nxt;
`ifdef ARB_ROUND_ROBIN_EN
      ptr       <= ptr_nxt;
`endif
    end
  end

  // Index of the current owner, decoded from the one-hot grant.
  always_comb begin
    own_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) own_idx = PW'(i);
    end
  end

  // An expiring owner is masked out of this edge's arbitration only.
  always_comb begin
    expired = (state == GRANT) && (burst_cnt >= MAX_CNT);
    elig    = expired ? (req & ~gnt) : req;
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Round-robin search starting at the pointer, wrapping at NREQ.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_vld && elig[rr_idx(ptr, k)]) begin
        win_vld = 1'b1;
        win_idx = rr_idx(ptr, k);
      end
    end
  end
`else
  // Fixed priority: lowest eligible index wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_vld && elig[k]) begin
        win_vld = 1'b1;
        win_idx = PW'(k);
      end
    end
  end
`endif

  // Next-state: continue the tenure, hand over with no bubble, or go idle.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    en_nxt    = en;
    d_nxt     = d;
    cnt_nxt   = burst_cnt;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_nxt   = ptr;
`endif
    if (state == GRANT && req[own_idx] && burst_cnt < MAX_CNT) begin
      d_nxt   = req_d[own_idx];
      cnt_nxt = burst_cnt + 4'd1;
    end else if (win_vld) begin
      state_nxt = GRANT;
      gnt_nxt   = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
      en_nxt    = 1'b1;
      d_nxt     = req_d[win_idx];
      cnt_nxt   = 4'd1;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_nxt   = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
`endif
    end else begin
      state_nxt = IDLE;
      gnt_nxt   = '0;
      en_nxt    = 1'b0;
      d_nxt     = 1'b0;
      cnt_nxt   = '0;
    end
  end

endmodule

// File: tb/tb_dff_write_arbiter.sv
// tb_dff_write_arbiter: vector table, directed corner sequences and a
// randomized run against a behavioural arbiter model (NREQ=4, MAX_BURST=4).
module tb_dff_write_arbiter;

  localparam int N   = 4;
  localparam int MAX = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req, req_d;
  logic         q;
  logic [N-1:0] gnt;
  logic         en, d, busy, q_out;

  int n_checks = 0;
  int n_fail   = 0;

  dff_write_arbiter #(.NREQ(N), .MAX_BURST(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_d(req_d), .q(q),
    .gnt(gnt), .en(en), .d(d), .busy(busy), .q_out(q_out)
  );

  always #5 clk = ~clk;

  // The shared flip-flop being arbitrated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else if (en) q <= d;
  end

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] rd;
    logic [3:0] g;
    logic       e;
    logic       dd;
    logic       b;
    logic       qq;
  } vec_t;

  vec_t tbl [14];

  // Behavioural model: owner index (-1 = none), tenure length, rr pointer.
  int   m_owner, m_cnt, m_ptr;
  logic m_d, m_q;

  function automatic void model_reset();
    m_owner = -1; m_cnt = 0; m_ptr = 0; m_d = 1'b0; m_q = 1'b0;
  endfunction

  function automatic void model_step(input logic [N-1:0] r, input logic [N-1:0] rd);
    int excl, win, c;
    if (m_owner >= 0) m_q = m_d;
    if (m_owner >= 0 && r[m_owner] && m_cnt < MAX) begin
      m_cnt = m_cnt + 1;
      m_d   = rd[m_owner];
      return;
    end
    excl = (m_owner >= 0 && m_cnt == MAX) ? m_owner : -1;
    win  = -1;
    for (int k = 0; k < N; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      c = (m_ptr + k) % N;
`else
      c = k;
`endif
      if (win < 0 && r[c] && c != excl) win = c;
    end
    if (win >= 0) begin
      m_owner = win; m_cnt = 1; m_d = rd[win]; m_ptr = (win + 1) % N;
    end else begin
      m_owner = -1; m_cnt = 0; m_d = 1'b0;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] rd);
    req = r; req_d = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r, rd, prev_r;
    int blk, idx;

    tbl[0]  = '{4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[13] = '{4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset with every requester active, then first grant after release.
    rst_n = 1'b0; req = 4'b1111; req_d = 4'b1111;
    #2;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_en", 32'(en), 32'h0);
    chk("rst_d", 32'(d), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, 4'b0000);
    chk("rel_gnt", 32'(gnt), 32'b0001);
    chk("rel_en", 32'(en), 32'h1);
    step(4'b0000, 4'b0000);
    chk("drop_gnt", 32'(gnt), 32'h0);

    // Vector table: short two-cycle write, then a lone requester held.
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].r, tbl[i].rd);
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].g));
      chk($sformatf("tbl%0d_en", i), 32'(en), 32'(tbl[i].e));
      chk($sformatf("tbl%0d_d", i), 32'(d), 32'(tbl[i].dd));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].b));
      chk($sformatf("tbl%0d_q", i), 32'(q_out), 32'(tbl[i].qq));
    end

    // All four requesting: tenures of MAX cycles, no enable bubbles.
    do_reset();
    for (int c = 0; c < 17; c++) begin
      step(4'b1111, 4'b1010);
      blk = c / MAX;
`ifdef ARB_ROUND_ROBIN_EN
      idx = blk % N;
`else
      idx = blk % 2;
`endif
      chk($sformatf("all_gnt%0d", c), 32'(gnt), 32'(1) << idx);
      chk($sformatf("all_en%0d", c), 32'(en), 32'h1);
      chk($sformatf("all_d%0d", c), 32'(d), 32'((4'b1010 >> idx) & 4'b0001));
    end

    // Reset in the middle of a grant, then restart from pointer 0.
    do_reset();
    step(4'b0010, 4'b0010);
    step(4'b0010, 4'b0010);
    chk("mid_pre_gnt", 32'(gnt), 32'b0010);
    rst_n = 1'b0;
    #2;
    chk("mid_gnt", 32'(gnt), 32'h0);
    chk("mid_en", 32'(en), 32'h0);
    chk("mid_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0110, 4'b0000);
    chk("mid_rel_gnt", 32'(gnt), 32'b0010);

    // Two requesters alternate whole tenures.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      step(4'b0110, 4'b0000);
      chk($sformatf("pair_gnt%0d", c), 32'(gnt), ((c / MAX) % 2 == 0) ? 32'b0010 : 32'b0100);
      chk($sformatf("pair_en%0d", c), 32'(en), 32'h1);
    end

    // Randomized run against the model, with occasional async resets.
    do_reset();
    model_reset();
    prev_r = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #2;
        model_reset();
        chk($sformatf("rnd%0d_rst_gnt", c), 32'(gnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
      end
      r  = ($urandom_range(0, 9) < 7) ? prev_r : N'($urandom_range(0, 15));
      rd = N'($urandom_range(0, 15));
      prev_r = r;
      step(r, rd);
      model_step(r, rd);
      chk($sformatf("rnd%0d_gnt", c), 32'(gnt), (m_owner >= 0) ? (32'(1) << m_owner) : 32'h0);
      chk($sformatf("rnd%0d_en", c), 32'(en), 32'(m_owner >= 0));
      chk($sformatf("rnd%0d_d", c), 32'(d), 32'(m_d));
      chk($sformatf("rnd%0d_busy", c), 32'(busy), 32'(m_owner >= 0));
      chk($sformatf("rnd%0d_q", c), 32'(q_out), 32'(m_q));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dff_write_arbiter.md
# dff_write_arbiter

Shares the single enabled D flip-flop datapath (`clk`, `en`, `d`, `q`) among `NREQ` requesters. The arbiter grants write access to one requester at a time and drives the flip-flop's `en` and `d` from the granted requester. It bounds each requester's tenure to `MAX_BURST` cycles. It sits between the requesters and the `top` flip-flop instance; `q` feeds back only for status.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `MAX_BURST`, 4: maximum consecutive grant cycles per tenure, 1..15.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in `NREQ`: per-requester write request, level.
- `req_d` in `NREQ`: per-requester data bit, sampled while granted.
- `q` in 1: flip-flop output, read back.
- `gnt` out `NREQ`: one-hot grant, registered.
- `en` out 1: flip-flop enable, registered; equals `|gnt`.
- `d` out 1: flip-flop data, registered.
- `busy` out 1: high when state is GRANT.
- `q_out` out 1: pass-through of `q` for requesters.

## Operation
- Reset values: `gnt`=0, `en`=0, `d`=0, `busy`=0, state IDLE, `burst_cnt`=0, RR pointer=0, `excl`=none.
- FSM states: IDLE and GRANT.
- **IDLE**
  - If any eligible `req` is high, pick a winner at the edge: `gnt` <= onehot(winner), `en` <= 1, `d` <= `req_d[winner]`, `burst_cnt` <= 1, go to GRANT.
  - Otherwise hold `gnt`=0, `en`=0, `d`=0.
- **GRANT** (owner = index of `gnt`)
  - Continue: if `req[owner]`=1 and `burst_cnt` < `MAX_BURST`, keep `gnt`, set `d` <= `req_d[owner]`, `burst_cnt`++.
  - Expiry or drop: if `req[owner]`=0, or `burst_cnt`=`MAX_BURST`, re-arbitrate among eligible requesters. If there is a winner, switch grant in the same edge (no bubble) and set `burst_cnt` <= 1. If there is none, go to IDLE with `gnt`=0 and `en`=0.
- **Eligibility**
  - On burst expiry (not on voluntary drop), the expired owner is marked `excl` for exactly the next arbitration.
  - A lone requester therefore sees one IDLE cycle (`en`=0) after each `MAX_BURST` tenure.
  - `excl` clears after that arbitration, whether or not a winner is found.
- **Winner selection**: round-robin (see Configuration). The RR pointer is updated to winner+1 mod `NREQ` on every new grant.
- Width rules:
  - `burst_cnt` is 4 bits.
  - The pointer is `$clog2(NREQ)` bits and wraps from `NREQ-1` to 0.
- `req_d` of non-granted requesters is ignored.
- A `req` deasserted in the same cycle it would win is not granted.

## Timing
- Request to grant: `req` high before edge N gives `gnt`/`en`/`d` valid after edge N, so latency is 1 cycle.
- Flip-flop `q` shows the written bit after edge N+1, so request to `q` is 2 cycles.
- Owner switch on expiry is zero-bubble when another requester is eligible.
- Reset mid-operation: `rst_n` low clears all outputs immediately (asynchronous), with no completion of the in-flight write. After release, arbitration restarts from pointer 0 on the first edge with `rst_n` high.
- Simultaneous `req` rise of several requesters: exactly one grant; `gnt` is never multi-hot.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: the search starts at the RR pointer and proceeds upward, wrapping at `NREQ`.
- Undefined: fixed priority, lowest eligible index wins, and the pointer logic is removed. The `excl` rule still applies, so a higher-priority requester cannot starve others beyond one tenure while another is requesting.

## Test plan
(`NREQ`=4, `MAX_BURST`=4, `ARB_ROUND_ROBIN_EN` defined unless noted.)
1. Reset: `rst_n`=0 with `req`=1111 → `gnt`=0000, `en`=0, `d`=0, `busy`=0. Release → `gnt`=0001 after first edge.
2. `req`=0100, `req_d[2]`=1 held 2 cycles → `gnt`=0100 for 2 cycles, `en`=1, `d`=1; `q`=1 one cycle later; then `gnt`=0000.
3. `req`=1111 held → `gnt` sequence 0001×4, 0010×4, 0100×4, 1000×4, 0001, with no `en` bubbles.
4. `req`=0001 held 10 cycles → `gnt` 0001×4, 0000×1 (`en`=0), 0001×4, 0000×1.
5. Reset mid-grant: `rst_n` low while `gnt`=0010 → `gnt`=0000, `en`=0 immediately. After release with `req`=0110 → `gnt`=0010 (pointer 0).
6. Macro undefined, `req`=0110 held → `gnt` 0010×4, 0100×4, 0010×4; with `req`=0010 only → 0010×4, 0000×1, repeating.
